// File: rtl/seg_pkg.sv
// Shared segment definitions for the 7-segment scan driver.
// Bit order of seg_t is a (MSB) .. g (LSB), so '0' decodes to 7'h7E.
package seg_pkg;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_t;

    localparam seg_t OFF_DIGIT  = seg_t'(7'b000_0000);
    localparam seg_t DASH_DIGIT = seg_t'(7'b000_0001);

endpackage

// File: rtl/seg_decode.sv
// BCD to 7-segment decoder. Codes 10..15 are shown as a dash (segment g).
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    // Pure lookup; the caller decides whether the digit is lit.
    always_comb begin
        seg_o = DASH_DIGIT;
        case (bcd_i)
            4'd0: seg_o = seg_t'(7'h7E);
            4'd1: seg_o = seg_t'(7'h30);
            4'd2: seg_o = seg_t'(7'h6D);
            4'd3: seg_o = seg_t'(7'h79);
            4'd4: seg_o = seg_t'(7'h33);
            4'd5: seg_o = seg_t'(7'h5B);
            4'd6: seg_o = seg_t'(7'h5F);
            4'd7: seg_o = seg_t'(7'h70);
            4'd8: seg_o = seg_t'(7'h7F);
            4'd9: seg_o = seg_t'(7'h7B);
            default: seg_o = DASH_DIGIT;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous double buffering,
// per-digit blank/flash and 4-level PWM brightness.
// Optional macro SEG_SCAN_DEADTIME_EN: blanks the first two cycles of every
// digit slot to suppress ghosting between adjacent digits.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [NUM_DIGITS-1:0][3:0] load_bcd,
    input  logic [NUM_DIGITS-1:0]      load_blank,
    input  logic [NUM_DIGITS-1:0]      load_flash,
    input  logic [1:0]                 brightness,
    output logic [6:0]                 seg_out,
    output logic [NUM_DIGITS-1:0]      dig_en,
    output logic                       frame_start
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Lit window length in cycles for a brightness code.
    function automatic logic [SW:0] on_time(input logic [1:0] b);
        return (SW+1)'((int'(b) + 1) * (SCAN_DIV / 4));
    endfunction

    // Scan counters
    logic [SW-1:0] slot_q, slot_d;
    logic [DW-1:0] dig_q, dig_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;

    // Buffers
    logic                       pending_q;
    logic [NUM_DIGITS-1:0][3:0] shd_bcd_q, act_bcd_q;
    logic [NUM_DIGITS-1:0]      shd_blank_q, act_blank_q;
    logic [NUM_DIGITS-1:0]      shd_flash_q, act_flash_q;
    logic [1:0]                 bright_q;

    // Outputs
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic                  fs_q, fs_d;

    logic       slot_end, dig_last, frame_last, frame_begin, frame_end, xfer, lit;
    logic [1:0] eff_bright;
    logic [3:0] sel_bcd;
    seg_t       dec_seg;

    assign slot_end    = (slot_q == SW'(SCAN_DIV - 1));
    assign dig_last    = (dig_q == DW'(NUM_DIGITS - 1));
    assign frame_last  = (frame_q == FW'(BLINK_FRAMES - 1));
    assign frame_begin = (slot_q == '0) && (dig_q == '0);
    assign frame_end   = slot_end && dig_last;

    // Ready is held low during reset even though pending is already clear.
    assign load_ready = !pending_q && !rst;
    assign xfer       = load_valid && load_ready;

    // Next-state for the slot / digit / frame / blink counter chain.
    always_comb begin
        slot_d  = slot_end ? '0 : slot_q + 1'b1;
        dig_d   = dig_q;
        frame_d = frame_q;
        blink_d = blink_q;
        if (slot_end) begin
            dig_d = dig_last ? '0 : dig_q + 1'b1;
        end
        if (frame_end) begin
            frame_d = frame_last ? '0 : frame_q + 1'b1;
            if (frame_last) begin
                blink_d = ~blink_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            dig_q   <= '0;
            frame_q <= '0;
            blink_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end

    // Shadow capture on handshake; shadow->active only at the frame boundary.
    // Both cannot happen in one cycle: capture needs pending clear, copy needs it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= 1'b0;
            shd_bcd_q   <= '0;
            shd_blank_q <= '1;
            shd_flash_q <= '0;
            act_bcd_q   <= '0;
            act_blank_q <= '1;
            act_flash_q <= '0;
        end else if (xfer) begin
            pending_q   <= 1'b1;
            shd_bcd_q   <= load_bcd;
            shd_blank_q <= load_blank;
            shd_flash_q <= load_flash;
        end else if (frame_end && pending_q) begin
            pending_q   <= 1'b0;
            act_bcd_q   <= shd_bcd_q;
            act_blank_q <= shd_blank_q;
            act_flash_q <= shd_flash_q;
        end
    end

    // Brightness is latched at frame start so a frame is uniformly dimmed.
    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= '0;
        end else if (frame_begin) begin
            bright_q <= brightness;
        end
    end

    assign sel_bcd = act_bcd_q[dig_q];

    seg_decode u_decode (
        .bcd_i (sel_bcd),
        .seg_o (dec_seg)
    );

    // Lit decision for the current slot cycle; the first frame cycle uses the
    // brightness being sampled right now rather than the stale latch.
    always_comb begin
        eff_bright = frame_begin ? brightness : bright_q;
        lit = ({1'b0, slot_q} < on_time(eff_bright))
              && !act_blank_q[dig_q]
              && !(act_flash_q[dig_q] && blink_q);
`ifdef SEG_SCAN_DEADTIME_EN
        lit = lit && (slot_q >= SW'(2));
`endif
        dig_en_d = '0;
        if (lit) begin
            dig_en_d[dig_q] = 1'b1;
        end
        seg_d = lit ? dec_seg : OFF_DIGIT;
        fs_d  = frame_begin;
    end

    // Output registers, one cycle behind the counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= OFF_DIGIT;
            dig_en_q <= '0;
            fs_q     <= 1'b0;
        end else begin
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
            fs_q     <= fs_d;
        end
    end

    assign seg_out     = seg_q;
    assign dig_en      = dig_en_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, 8-cycle slots, 2-frame blink).
// The reference derives counter state from the absolute cycle count since reset.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BF = 2;
    localparam int FL = ND * SD;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load_valid = 1'b0;
    logic                load_ready;
    logic [ND-1:0][3:0]  load_bcd = '0;
    logic [ND-1:0]       load_blank = '0;
    logic [ND-1:0]       load_flash = '0;
    logic [1:0]          brightness = '0;
    logic [6:0]          seg_out;
    logic [ND-1:0]       dig_en;
    logic                frame_start;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_bcd    (load_bcd),
        .load_blank  (load_blank),
        .load_flash  (load_flash),
        .brightness  (brightness),
        .seg_out     (seg_out),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};

    int n_chk = 0;
    int n_err = 0;

    // Reference state
    int                 n = 0;
    bit                 m_pend = 1'b0;
    logic [ND-1:0][3:0] m_sbcd = '0, m_abcd = '0;
    logic [ND-1:0]      m_sblank = '1, m_ablank = '1;
    logic [ND-1:0]      m_sflash = '0, m_aflash = '0;
    logic [1:0]         m_bsamp = '0;
    logic [6:0]         e_seg = '0;
    logic [ND-1:0]      e_dig = '0;
    logic               e_fs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the reference by one clock edge using the inputs now applied.
    task automatic step();
        int slot, dig, fn, on;
        bit blink, lit;
        if (rst) begin
            e_seg = '0; e_dig = '0; e_fs = 1'b0;
            n = 0; m_pend = 1'b0;
            m_sblank = '1; m_ablank = '1;
            m_sflash = '0; m_aflash = '0;
            m_sbcd = '0; m_abcd = '0;
            return;
        end
        slot  = n % SD;
        dig   = (n / SD) % ND;
        fn    = n / FL;
        blink = ((fn / BF) % 2) == 1;
        if (n % FL == 0) m_bsamp = brightness;
        on  = (int'(m_bsamp) + 1) * SD / 4;
        lit = (slot < on) && !m_ablank[dig] && !(m_aflash[dig] && blink);
`ifdef SEG_SCAN_DEADTIME_EN
        lit = lit && (slot >= 2);
`endif
        e_seg = lit ? seg_tbl[m_abcd[dig]] : 7'h00;
        e_dig = lit ? ND'(1 << dig) : '0;
        e_fs  = (n % FL == 0);
        if ((n % FL == FL - 1) && m_pend) begin
            m_abcd = m_sbcd; m_ablank = m_sblank; m_aflash = m_sflash;
            m_pend = 1'b0;
        end else if (load_valid && !m_pend) begin
            m_sbcd = load_bcd; m_sblank = load_blank; m_sflash = load_flash;
            m_pend = 1'b1;
        end
        n++;
    endtask

    // One cycle: check outputs of the previous edge, apply new inputs, predict.
    task automatic tick(input bit r, input bit v, input logic [ND-1:0][3:0] b,
                        input logic [ND-1:0] bl, input logic [ND-1:0] fl,
                        input logic [1:0] br);
        @(negedge clk);
        chk("seg_out", 32'(seg_out), 32'(e_seg));
        chk("dig_en", 32'(dig_en), 32'(e_dig));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("load_ready", 32'(load_ready), 32'(!m_pend && !rst));
        rst = r; load_valid = v; load_bcd = b;
        load_blank = bl; load_flash = fl; brightness = br;
        step();
    endtask

    logic [ND-1:0][3:0] rb;
    logic [ND-1:0][3:0] base_bcd;
    bit                 rv, rr;

    initial begin
        base_bcd = {4'd3, 4'd2, 4'd1, 4'd0};
        // Reset, then the reference digit pattern at full brightness.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0, '0, '0, 2'd3);
        tick(1'b0, 1'b1, base_bcd, '0, '0, 2'd3);
        // Competing load while pending must be ignored.
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, {4'd9, 4'd9, 4'd9, 4'd9}, '0, '0, 2'd3);
        for (int i = 0; i < 70; i++) tick(1'b0, 1'b0, '0, '0, '0, 2'd3);
        // Dimmest level, then a mid-frame change.
        for (int i = 0; i < 45; i++) tick(1'b0, 1'b0, '0, '0, '0, 2'd0);
        for (int i = 0; i < 45; i++) tick(1'b0, 1'b0, '0, '0, '0, 2'd1);
        // Flash on digit 2, dash and blank on others.
        tick(1'b0, 1'b1, {4'd7, 4'd5, 4'd12, 4'd8}, 4'b0000, 4'b0100, 2'd3);
        for (int i = 0; i < 5 * FL; i++) tick(1'b0, 1'b0, '0, '0, '0, 2'd3);
        tick(1'b0, 1'b1, base_bcd, 4'b0010, 4'b0000, 2'd3);
        for (int i = 0; i < 2 * FL; i++) tick(1'b0, 1'b0, '0, '0, '0, 2'd3);
        // Reset mid-slot: display must stay blank afterwards.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, '0, '0, 2'd3);
        tick(1'b1, 1'b0, '0, '0, '0, 2'd3);
        for (int i = 0; i < 2 * FL; i++) tick(1'b0, 1'b0, '0, '0, '0, 2'd3);
        // Randomized traffic; loads are rare except at frame end so that
        // transfers coincident with the copy cycle get exercised.
        for (int i = 0; i < 2500; i++) begin
            for (int d = 0; d < ND; d++) rb[d] = 4'($urandom_range(0, 15));
            rv = ($urandom_range(0, 49) == 0) ||
                 ((n % FL == FL - 1) && ($urandom_range(0, 1) == 1));
            rr = ($urandom_range(0, 399) == 0);
            tick(rr, rv, rb, ND'($urandom & $urandom), ND'($urandom),
                 2'($urandom_range(0, 3)));
        end
        tick(1'b0, 1'b0, '0, '0, '0, 2'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed 7-segment digits, range 2..16.
REQ-002 Parameter SCAN_DIV, default 1024: clock cycles per digit slot, minimum 8, multiple of 4.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period, minimum 1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 load_valid  input  1  new frame offered.
REQ-007 load_ready  output  1  frame can be accepted.
REQ-008 load_bcd  input  NUM_DIGITS x 4  per-digit BCD; 10..15 means dash.
REQ-009 load_blank  input  NUM_DIGITS  per-digit force-off.
REQ-010 load_flash  input  NUM_DIGITS  per-digit blink enable.
REQ-011 brightness  input  2  PWM level 0..3.
REQ-012 seg_out  output  7  segments a..g of the selected digit, active-high.
REQ-013 dig_en  output  NUM_DIGITS  one-hot or all-zero digit select.
REQ-014 frame_start  output  1  one-cycle pulse when digit 0's slot begins.

Function
REQ-015 Transfer SHALL occur when load_valid and load_ready are both high in the same cycle; load_bcd, load_blank and load_flash are captured into a shadow buffer and a pending flag is set.
REQ-016 load_ready SHALL equal not-pending; load_valid without load_ready SHALL be held by the source with no capture.
REQ-017 At the last cycle of the last digit slot, if pending, the shadow buffer SHALL copy to the active buffer and pending SHALL clear; no mid-frame update.
REQ-018 A transfer in the same cycle as a frame end SHALL remain pending until the following frame end.
REQ-019 Slot counter SHALL count 0..SCAN_DIV-1; on wrap the digit index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-020 Frame counter SHALL count 0..BLINK_FRAMES-1 at digit-index wrap; blink_phase SHALL toggle on its wrap, starting at 0 (visible).
REQ-021 brightness SHALL be sampled at frame start; on_time = (brightness+1)*SCAN_DIV/4 cycles.
REQ-022 Digit i is lit in a slot cycle iff slot count < on_time, not blank[i], and not (flash[i] and blink_phase=1).
REQ-023 When lit, dig_en SHALL be one-hot at index i and seg_out the decoded pattern: 0..9 standard, 10..15 g only; otherwise dig_en and seg_out SHALL be zero.
REQ-024 seg_out, dig_en and frame_start SHALL be registered, one cycle after the counter state they reflect.
REQ-025 seg_out SHALL never be nonzero while dig_en is zero.

Reset
REQ-026 While rst is high: counters, digit index, blink_phase and pending SHALL be 0; active and shadow blank bits SHALL be all 1; seg_out, dig_en and frame_start SHALL be 0; load_ready SHALL be 0.
REQ-027 Reset mid-frame SHALL discard pending data; the first frame_start SHALL occur one cycle after rst falls.

Configuration
REQ-028 Macro SEG_SCAN_DEADTIME_EN defined: dig_en and seg_out SHALL be forced zero for slot counts 0 and 1 of every slot (ghost suppression), reducing effective on_time by 2.
REQ-029 Macro undefined: no dead time; REQ-022 applies unchanged.

Structure
REQ-030 Shared package seg_pkg SHALL hold the digit struct typedef (a..g), OFF_DIGIT and DASH_DIGIT constants.
REQ-031 BCD-to-segment decode SHALL be a sub-module seg_decode, instantiated once on the selected digit.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLINK_FRAMES=2)
REQ-032 Load bcd {3,2,1,0}, no blank or flash, brightness 3 -> after next frame end, digit 0 slot shows 0x7E for 8 cycles with dig_en=0001, then digit 1 shows 0x30.
REQ-033 brightness 0 -> each slot lit 2 cycles and dark 6; a change mid-frame takes effect only at the next frame_start.
REQ-034 flash on digit 2 -> digit 2 lit for frames 0-1, dark for frames 2-3, period 4 frames; other digits unaffected.
REQ-035 Second load_valid while pending -> load_ready=0 and data ignored; transfer coincident with frame end -> shown one frame later.
REQ-036 bcd 12 -> seg_out=0x01; blank bit set -> dig_en=0 for that slot; rst asserted mid-slot -> all outputs zero the next cycle and blank display until a new load.
